hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined RISC-V core. It tracks destination registers of up to MAX_LAT in-flight instructions in an age-ordered shift pipeline. For each issuing instruction it produces per-operand forwarding selects (generalising the fixed three-way Rs1/Rs2 forward sources to MAX_LAT+1 sources) and a stall whenever a needed result is not yet forwardable. It sits beside the issue/decode stage and drives the operand-forward muxes and the pipeline enable.

---
 rtl/hazard_scoreboard.sv | 154 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: age-ordered slot pipeline of in-flight writers with per-operand forward selects and issue stall.
// Optional long-latency unit tracking is enabled by defining LONG_LATENCY_EN.
module hazard_scoreboard #(
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = $clog2(REG_COUNT),
  parameter int MAX_LAT    = 4,
  parameter int FWD_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [FWD_W-1:0]      issue_lat,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  flush,
  output logic                  stall,
  output logic [FWD_W-1:0]      rs1_fwd,
  output logic [FWD_W-1:0]      rs2_fwd,
  output logic                  accepted
`ifdef LONG_LATENCY_EN
  ,
  input  logic                  lu_start,
  input  logic [REG_ADDR_W-1:0] lu_rd,
  input  logic                  lu_done,
  output logic                  lu_busy
`endif
);

  logic [MAX_LAT:1]      slot_valid_r;
  logic [MAX_LAT:1]      slot_wr_r;
  logic [REG_ADDR_W-1:0] slot_rd_r  [1:MAX_LAT];
  logic [FWD_W-1:0]      slot_lat_r [1:MAX_LAT];

  logic [FWD_W-1:0] lat_clamp_s;
  logic             rs1_ready_s;
  logic             rs2_ready_s;
  logic             lu_block_s;
  logic             lu_take_s;
  logic             stall_s;
  logic             accepted_s;

  // Youngest matching writer decides; an older ready copy is shadowed by a younger pending one.
  function automatic logic [FWD_W:0] lookup(input logic [REG_ADDR_W-1:0] rs, input logic used);
    logic             found;
    logic             hit;
    logic [FWD_W-1:0] age;
    logic [FWD_W-1:0] lat;
    logic             ready;
    found = 1'b0;
    age   = '0;
    lat   = '0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      hit   = ~found & slot_valid_r[k] & slot_wr_r[k] & (slot_rd_r[k] == rs);
      age   = hit ? FWD_W'(k) : age;
      lat   = hit ? slot_lat_r[k] : lat;
      found = found | hit;
    end
    if (!used || rs == '0 || !found) begin
      return {1'b1, {FWD_W{1'b0}}};
    end else if (age >= lat) begin
      return {1'b1, age};
    end else begin
      ready = 1'b0;
      return {ready, {FWD_W{1'b0}}};
    end
  endfunction

  // Out-of-range latencies are treated as the slowest legal one.
  always_comb begin
    if (issue_lat == '0 || issue_lat > FWD_W'(MAX_LAT)) begin
      lat_clamp_s = FWD_W'(MAX_LAT);
    end else begin
      lat_clamp_s = issue_lat;
    end
  end

  // Operand lookup against the slot pipeline.
  always_comb begin
    {rs1_ready_s, rs1_fwd} = lookup(issue_rs1, rs1_used);
    {rs2_ready_s, rs2_fwd} = lookup(issue_rs2, rs2_used);
  end

`ifdef LONG_LATENCY_EN
  logic                  lu_busy_r;
  logic [REG_ADDR_W-1:0] lu_rd_r;

  // Block RAW/WAW against the busy unit and any second start while it is occupied.
  always_comb begin
    lu_block_s = lu_busy_r & (lu_start
                 | (rs1_used & (issue_rs1 != '0) & (issue_rs1 == lu_rd_r))
                 | (rs2_used & (issue_rs2 != '0) & (issue_rs2 == lu_rd_r))
                 | (issue_we & (issue_rd != '0) & (issue_rd == lu_rd_r)));
    lu_take_s  = accepted_s & lu_start;
  end

  // Long-latency busy flag; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lu_busy_r <= 1'b0;
      lu_rd_r   <= '0;
    end else if (lu_take_s) begin
      lu_busy_r <= 1'b1;
      lu_rd_r   <= lu_rd;
    end else if (lu_done) begin
      lu_busy_r <= 1'b0;
    end
  end

  assign lu_busy = lu_busy_r;
`else
  assign lu_block_s = 1'b0;
  assign lu_take_s  = 1'b0;
`endif

  // Issue decision; flush kills the issue regardless of readiness.
  always_comb begin
    stall_s    = issue_valid & (~rs1_ready_s | ~rs2_ready_s | lu_block_s);
    accepted_s = issue_valid & ~stall_s & ~flush;
  end

  assign stall    = stall_s;
  assign accepted = accepted_s;

  // Slot pipeline: shift every cycle, insert the accepted instruction or a bubble at age 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid_r <= '0;
      slot_wr_r    <= '0;
      for (int k = 1; k <= MAX_LAT; k++) begin
        slot_rd_r[k]  <= '0;
        slot_lat_r[k] <= '0;
      end
    end else begin
      slot_valid_r[1] <= accepted_s & ~lu_take_s;
      slot_wr_r[1]    <= accepted_s & ~lu_take_s & issue_we & (issue_rd != '0);
      slot_rd_r[1]    <= issue_rd;
      slot_lat_r[1]   <= lat_clamp_s;
      for (int k = 2; k <= MAX_LAT; k++) begin
        slot_valid_r[k] <= slot_valid_r[k-1];
        slot_wr_r[k]    <= slot_wr_r[k-1];
        slot_rd_r[k]    <= slot_rd_r[k-1];
        slot_lat_r[k]   <= slot_lat_r[k-1];
      end
      if (flush) begin
        slot_valid_r[2] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; expected values are hand-derived from slot ages and latencies.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset_n;
  logic       issue_valid;
  logic       issue_we;
  logic [4:0] issue_rd;
  logic [2:0] issue_lat;
  logic [4:0] issue_rs1;
  logic [4:0] issue_rs2;
  logic       rs1_used;
  logic       rs2_used;
  logic       flush;
  logic       stall;
  logic [2:0] rs1_fwd;
  logic [2:0] rs2_fwd;
  logic       accepted;
`ifdef LONG_LATENCY_EN
  logic       lu_start;
  logic [4:0] lu_rd;
  logic       lu_done;
  logic       lu_busy;
`endif

  int errors;
  int checks;

  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .rs1_used(rs1_used), .rs2_used(rs2_used), .flush(flush), .stall(stall),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .accepted(accepted)
`ifdef LONG_LATENCY_EN
    , .lu_start(lu_start), .lu_rd(lu_rd), .lu_done(lu_done), .lu_busy(lu_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic st, input logic [2:0] f1,
                            input logic [2:0] f2, input logic acc);
    chk({tag, ".stall"}, 32'(stall), 32'(st));
    chk({tag, ".rs1_fwd"}, 32'(rs1_fwd), 32'(f1));
    chk({tag, ".rs2_fwd"}, 32'(rs2_fwd), 32'(f2));
    chk({tag, ".accepted"}, 32'(accepted), 32'(acc));
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [2:0] lat,
                       input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
    issue_valid = v; issue_we = we; issue_rd = rd; issue_lat = lat;
    issue_rs1 = r1; issue_rs2 = r2; rs1_used = u1; rs2_used = u2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 5'd0, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (n) step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    flush = 1'b0;
`ifdef LONG_LATENCY_EN
    lu_start = 1'b0; lu_rd = 5'd0; lu_done = 1'b0;
`endif
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 3'd1, 5'd5, 5'd0, 1'b1, 1'b0);
    #2;
    expect_out("reset", 1'b0, 3'd0, 3'd0, 1'b1);
    flush = 1'b1;
    #1;
    chk("reset_flush.accepted", 32'(accepted), 32'd0);
    flush = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    idle(1);

    // ALU chain: x5 lat1, then readers at age 1 and age 2
    drive(1'b1, 1'b1, 5'd5, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    #2; expect_out("alu_prod", 1'b0, 3'd0, 3'd0, 1'b1);
    step();
    drive(1'b1, 1'b1, 5'd6, 3'd1, 5'd5, 5'd0, 1'b1, 1'b0);
    #2; expect_out("alu_dep1", 1'b0, 3'd1, 3'd0, 1'b1);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd1, 5'd5, 5'd6, 1'b1, 1'b1);
    #2; expect_out("alu_dep2", 1'b0, 3'd2, 3'd1, 1'b1);
    step();
    idle(4);

    // Load-use: one stall, then forward from age 2
    drive(1'b1, 1'b1, 5'd7, 3'd2, 5'd0, 5'd0, 1'b0, 1'b0);
    #2; expect_out("lw_prod", 1'b0, 3'd0, 3'd0, 1'b1);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd1, 5'd1, 5'd7, 1'b1, 1'b1);
    #2; expect_out("lw_use_stall", 1'b1, 3'd0, 3'd0, 1'b0);
    step();
    #2; expect_out("lw_use_go", 1'b0, 3'd0, 3'd2, 1'b1);
    step();
    idle(4);

    // x0 writes are never tracked
    drive(1'b1, 1'b1, 5'd0, 3'd4, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd1, 5'd0, 5'd0, 1'b1, 1'b1);
    #2; expect_out("x0_read", 1'b0, 3'd0, 3'd0, 1'b1);
    step();
    idle(4);

    // Two writers of x9 at ages 3 and 1: youngest wins
    drive(1'b1, 1'b1, 5'd9, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 5'd9, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd1, 5'd9, 5'd9, 1'b1, 1'b1);
    #2; expect_out("x9_youngest", 1'b0, 3'd1, 3'd1, 1'b1);
    step();
    idle(4);

    // lat=0 clamps to 4: reader one cycle behind stalls 3 cycles, then forwards from the retiring slot
    drive(1'b1, 1'b1, 5'd11, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd1, 5'd11, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2; expect_out($sformatf("clamp_stall%0d", i), 1'b1, 3'd0, 3'd0, 1'b0);
      step();
    end
    #2; expect_out("clamp_go", 1'b0, 3'd4, 3'd0, 1'b1);
    step();
    idle(4);

    // Flush kills the issue and the age-1 load of x3
    drive(1'b1, 1'b1, 5'd3, 3'd2, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd1, 5'd3, 5'd0, 1'b1, 1'b0);
    flush = 1'b1;
    #2; chk("flush.accepted", 32'(accepted), 32'd0);
    step();
    flush = 1'b0;
    #2; expect_out("post_flush", 1'b0, 3'd0, 3'd0, 1'b1);
    step();
    idle(4);

    // Reset mid-operation discards slots at once
    drive(1'b1, 1'b1, 5'd12, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 5'd0, 3'd1, 5'd12, 5'd0, 1'b1, 1'b0);
    #2; expect_out("pre_reset", 1'b0, 3'd1, 3'd0, 1'b1);
    reset_n = 1'b0;
    #1; expect_out("mid_reset", 1'b0, 3'd0, 3'd0, 1'b1);
    step();
    reset_n = 1'b1;
    #2; expect_out("after_reset", 1'b0, 3'd0, 3'd0, 1'b1);
    step();
    idle(1);

`ifdef LONG_LATENCY_EN
    // Long-latency op on x10 blocks readers until the cycle after lu_done
    drive(1'b1, 1'b1, 5'd10, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    lu_start = 1'b1; lu_rd = 5'd10;
    #2; chk("lu_start.accepted", 32'(accepted), 32'd1);
    step();
    lu_start = 1'b0;
    chk("lu_busy_set", 32'(lu_busy), 32'd1);
    drive(1'b1, 1'b0, 5'd0, 3'd1, 5'd10, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #2; expect_out($sformatf("lu_stall%0d", i), 1'b1, 3'd0, 3'd0, 1'b0);
      step();
    end
    lu_done = 1'b1;
    #2; chk("lu_done_cycle.stall", 32'(stall), 32'd1);
    step();
    lu_done = 1'b0;
    #2; expect_out("lu_release", 1'b0, 3'd0, 3'd0, 1'b1);
    chk("lu_busy_clear", 32'(lu_busy), 32'd0);
    step();
    idle(1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
